stat_pkt_meter: RTL and testbench
=================================

// Module: stat_pkt_meter
// PURPOSE
//  Upstream feeder of the per-flow statistics RAM stage. Watches a packet
//  stream bus (valid/sop/eop/empty, flow tag on SOP) and measures each packet
//  length in bytes. On a clean EOP it emits one rx_flow_num/pkt_size/pkt_size_en
//  update. Malformed or errored packets are dropped and counted.
// PARAMETERS
//  A_WIDTH     10  flow number width; must match the stats stage
//  DATA_BYTES  8   bytes per bus beat; power of 2, >=2
//  EMPTY_W     $clog2(DATA_BYTES)  width of pkt_empty_i (derived, do not override)
// PORTS
//  clk_i           in   1        single clock, all logic posedge
//  rst_n_i         in   1        asynchronous active-low reset
//  pkt_valid_i     in   1        beat present this cycle (no backpressure, always accepted)
//  pkt_sop_i       in   1        first beat of packet; qualified by valid
//  pkt_eop_i       in   1        last beat of packet; qualified by valid
//  pkt_empty_i     in   EMPTY_W  unused bytes in EOP beat; ignored unless eop
//  pkt_flow_num_i  in   A_WIDTH  flow tag; sampled on SOP beat only
//  pkt_err_i       in   1        packet bad; sampled on EOP beat only
//  rx_flow_num_o   out  A_WIDTH  flow of reported packet
//  pkt_size_o      out  16       packet length in bytes, saturating
//  pkt_size_en_o   out  1        1-cycle strobe: rx_flow_num_o/pkt_size_o valid
//  proto_err_o     out  1        1-cycle pulse on framing violation
//  drop_cnt_o      out  16       packets dropped since reset, saturates at 16'hFFFF
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, internal byte count 0; async assert, sync deassert
//    is the integrator's job. Reset mid-packet discards it: no strobe, no drop count.
//  - FSM states IDLE, IN_PKT. Beat = cycle with pkt_valid_i=1. Non-valid cycles change nothing.
//  - Beat bytes = DATA_BYTES - (eop ? pkt_empty_i : 0).
//  - IDLE, beat sop=1: latch flow, cnt=beat bytes. eop=1 -> finish (below), stay IDLE;
//    else -> IN_PKT.
//  - IDLE, beat sop=0: beat discarded, proto_err_o pulses, drop_cnt_o unchanged.
//  - IN_PKT, beat sop=0: cnt += beat bytes, saturating at 16'hFFFF. eop=1 -> finish, -> IDLE.
//  - IN_PKT, beat sop=1 (missing EOP): current packet aborted (no strobe), proto_err_o
//    pulses, drop_cnt_o+1; new beat handled exactly as IDLE sop=1 in the same cycle.
//  - Finish: pkt_err_i=0 -> next cycle pkt_size_en_o=1 for exactly 1 cycle with
//    pkt_size_o=final cnt, rx_flow_num_o=latched flow. pkt_err_i=1 -> no strobe, drop_cnt_o+1.
//  - Latency: strobe is registered, 1 cycle after EOP beat. rx_flow_num_o/pkt_size_o hold
//    last reported values between strobes.
//  - Throughput: single-beat packets every cycle -> strobe every cycle; EOP then SOP on the
//    next cycle has no bubble.
//  - Size width: accumulate in 17 bits or compare before add; never wraps. Max legal
//    report 16'hFFFF.
//  - Abort and EOP-error never coincide in one beat (sop+eop in IN_PKT = abort old + new
//    1-beat packet, which itself may finish/err). At most one drop_cnt increment per cause;
//    abort plus new-packet err in the same beat gives +2.
//  - drop_cnt_o saturates at 16'hFFFF; proto_err_o is a registered 1-cycle pulse aligned
//    with the strobe timing.
// TESTING (DATA_BYTES=8, A_WIDTH=10)
//  1. Beat sop=eop=1, empty=3, flow=5 -> next cycle en=1, size=5, flow=5; en=0 after.
//  2. 3 beats flow=9, empty=0 on EOP -> en 1 cycle after EOP, size=24, flow=9.
//  3. Same as 2 with 2 idle cycles between beats -> size=24, strobe only after EOP.
//  4. Packet flow=2 beats 1-2, then sop beat flow=7 (sop+eop, empty=0) -> proto_err pulse,
//     drop_cnt=1, single strobe size=8 flow=7.
//  5. 3-beat packet with pkt_err_i=1 on EOP -> no strobe, drop_cnt=1; valid non-sop beat in
//     IDLE -> proto_err pulse, drop_cnt still 1.
//  6. 8200-beat packet -> size=16'hFFFF. Then rst_n_i low mid-packet -> all outputs 0,
//     no strobe; next 2-beat packet, empty=1 -> size=15.

Source files
------------

// File: rtl/stat_pkt_meter.sv
// ---------------------------------------------------------------------------
// stat_pkt_meter
//   Measures the byte length of each packet on a beat-oriented stream bus and
//   hands one (flow, size) update per clean packet to the per-flow statistics
//   stage. Framing violations pulse proto_err_o. Errored or aborted packets
//   are dropped and counted in a saturating drop counter.
//
// Ports
//   clk_i, rst_n_i       clock (posedge) and asynchronous active-low reset
//   pkt_valid_i          beat present this cycle (always accepted)
//   pkt_sop_i/eop_i      first/last beat of a packet, qualified by valid
//   pkt_empty_i          unused bytes in the EOP beat
//   pkt_flow_num_i       flow tag, sampled on the SOP beat
//   pkt_err_i            packet bad, sampled on the EOP beat
//   rx_flow_num_o        flow of the reported packet (holds between strobes)
//   pkt_size_o           packet length in bytes, saturating at 16'hFFFF
//   pkt_size_en_o        1-cycle strobe, registered, one cycle after EOP
//   proto_err_o          1-cycle registered pulse on a framing violation
//   drop_cnt_o           dropped packets since reset, saturating
// ---------------------------------------------------------------------------
module stat_pkt_meter #(
  parameter int A_WIDTH    = 10,
  parameter int DATA_BYTES = 8,
  parameter int EMPTY_W    = $clog2(DATA_BYTES)
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               pkt_valid_i,
  input  logic               pkt_sop_i,
  input  logic               pkt_eop_i,
  input  logic [EMPTY_W-1:0] pkt_empty_i,
  input  logic [A_WIDTH-1:0] pkt_flow_num_i,
  input  logic               pkt_err_i,
  output logic [A_WIDTH-1:0] rx_flow_num_o,
  output logic [15:0]        pkt_size_o,
  output logic               pkt_size_en_o,
  output logic               proto_err_o,
  output logic [15:0]        drop_cnt_o
);

  typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} state_t;

  localparam logic [16:0] LP_BEAT_BYTES = 17'(DATA_BYTES);
  localparam logic [16:0] LP_SAT        = 17'h0_FFFF;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [15:0]          r_cnt;
  logic [A_WIDTH-1:0]   r_flow;
  logic [A_WIDTH-1:0]   r_rx_flow;
  logic [15:0]          r_size;
  logic                 r_size_en;
  logic                 r_proto_err;
  logic [15:0]          r_drop_cnt;

  logic [16:0]          w_beat_bytes;
  logic [16:0]          w_sum;
  logic [15:0]          w_cnt_sat;
  logic [15:0]          w_cnt_final;
  logic                 w_start;
  logic                 w_abort;
  logic                 w_stray;
  logic                 w_cont;
  logic                 w_finish;
  logic                 w_good;
  logic                 w_bad;
  logic [16:0]          w_drop_sum;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // -------------------------------------------------------------------------
  // Next-state logic. Any SOP restarts a packet; a lone EOP in IN_PKT ends it.
  // -------------------------------------------------------------------------
  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    w_state_nxt = r_state;
    if (pkt_valid_i) begin
      if (pkt_sop_i)                              w_state_nxt = pkt_eop_i ? IDLE : IN_PKT;
      else if (r_state == IN_PKT && pkt_eop_i)    w_state_nxt = IDLE;
    end
  end

  // -------------------------------------------------------------------------
  // Output / event decode
  // -------------------------------------------------------------------------
  always_comb begin
    w_start  = pkt_valid_i &  pkt_sop_i;
    w_abort  = pkt_valid_i &  pkt_sop_i & (r_state == IN_PKT);
    w_stray  = pkt_valid_i & ~pkt_sop_i & (r_state == IDLE);
    w_cont   = pkt_valid_i & ~pkt_sop_i & (r_state == IN_PKT);
    // An EOP finishes a packet only if a packet is open after this beat's SOP.
    w_finish = pkt_valid_i &  pkt_eop_i & (pkt_sop_i | (r_state == IN_PKT));
    w_good   = w_finish & ~pkt_err_i;
    w_bad    = w_finish &  pkt_err_i;

    w_beat_bytes = LP_BEAT_BYTES - (pkt_eop_i ? 17'(pkt_empty_i) : 17'd0);
    // 17-bit sum cannot wrap: clamp to 16'hFFFF.
    w_sum        = {1'b0, r_cnt} + w_beat_bytes;
    w_cnt_sat    = (w_sum > LP_SAT) ? 16'hFFFF : w_sum[15:0];
    w_cnt_final  = pkt_sop_i ? w_beat_bytes[15:0] : w_cnt_sat;

    // Abort and EOP-error are independent causes; both may land in one beat.
    w_drop_sum   = {1'b0, r_drop_cnt} + 17'(w_abort) + 17'(w_bad);
  end

  // -------------------------------------------------------------------------
  // Datapath and registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt       <= '0;
      r_flow      <= '0;
      r_rx_flow   <= '0;
      r_size      <= '0;
      r_size_en   <= 1'b0;
      r_proto_err <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      r_size_en   <= w_good;
      r_proto_err <= w_abort | w_stray;

      if (w_start) begin
        r_flow <= pkt_flow_num_i;
        r_cnt  <= w_beat_bytes[15:0];
      end else if (w_cont) begin
        r_cnt  <= w_cnt_sat;
      end

      if (w_good) begin
        // A single-beat packet reports the tag of this very beat.
        r_rx_flow <= pkt_sop_i ? pkt_flow_num_i : r_flow;
        r_size    <= w_cnt_final;
      end

      r_drop_cnt <= (w_drop_sum > LP_SAT) ? 16'hFFFF : w_drop_sum[15:0];
    end
  end

  assign rx_flow_num_o = r_rx_flow;
  assign pkt_size_o    = r_size;
  assign pkt_size_en_o = r_size_en;
  assign proto_err_o   = r_proto_err;
  assign drop_cnt_o    = r_drop_cnt;

endmodule

// File: tb/tb_stat_pkt_meter.sv
// ---------------------------------------------------------------------------
// tb_stat_pkt_meter
//   Directed bench for stat_pkt_meter (DATA_BYTES=8, A_WIDTH=10). Inputs are
//   driven 1 time unit after the rising edge; outputs are sampled at the same
//   point, i.e. after the edge that consumed the previous beat.
// ---------------------------------------------------------------------------
module tb_stat_pkt_meter;

  localparam int A_WIDTH    = 10;
  localparam int DATA_BYTES = 8;
  localparam int EMPTY_W    = $clog2(DATA_BYTES);

  logic               clk_i = 1'b0;
  logic               rst_n_i;
  logic               pkt_valid_i;
  logic               pkt_sop_i;
  logic               pkt_eop_i;
  logic [EMPTY_W-1:0] pkt_empty_i;
  logic [A_WIDTH-1:0] pkt_flow_num_i;
  logic               pkt_err_i;
  logic [A_WIDTH-1:0] rx_flow_num_o;
  logic [15:0]        pkt_size_o;
  logic               pkt_size_en_o;
  logic               proto_err_o;
  logic [15:0]        drop_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  stat_pkt_meter #(.A_WIDTH(A_WIDTH), .DATA_BYTES(DATA_BYTES)) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .pkt_valid_i    (pkt_valid_i),
    .pkt_sop_i      (pkt_sop_i),
    .pkt_eop_i      (pkt_eop_i),
    .pkt_empty_i    (pkt_empty_i),
    .pkt_flow_num_i (pkt_flow_num_i),
    .pkt_err_i      (pkt_err_i),
    .rx_flow_num_o  (rx_flow_num_o),
    .pkt_size_o     (pkt_size_o),
    .pkt_size_en_o  (pkt_size_en_o),
    .proto_err_o    (proto_err_o),
    .drop_cnt_o     (drop_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks all five outputs at once.
  task automatic check_out(input string tag, input logic en, input logic [15:0] size,
                           input logic [A_WIDTH-1:0] flow, input logic perr,
                           input logic [15:0] drops);
    check({tag, ".en"},   32'(pkt_size_en_o), 32'(en));
    check({tag, ".size"}, 32'(pkt_size_o),    32'(size));
    check({tag, ".flow"}, 32'(rx_flow_num_o), 32'(flow));
    check({tag, ".perr"}, 32'(proto_err_o),   32'(perr));
    check({tag, ".drop"}, 32'(drop_cnt_o),    32'(drops));
  endtask

  task automatic drive(input logic v, input logic s, input logic e,
                       input logic [EMPTY_W-1:0] emp, input logic [A_WIDTH-1:0] fl,
                       input logic er);
    pkt_valid_i    = v;
    pkt_sop_i      = s;
    pkt_eop_i      = e;
    pkt_empty_i    = emp;
    pkt_flow_num_i = fl;
    pkt_err_i      = er;
    @(posedge clk_i);
    #1;
  endtask

  task automatic beat(input logic s, input logic e, input logic [EMPTY_W-1:0] emp,
                      input logic [A_WIDTH-1:0] fl, input logic er);
    drive(1'b1, s, e, emp, fl, er);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    idle();
    idle();
    rst_n_i = 1'b1;
    idle();
  endtask

  initial begin
    rst_n_i = 1'b0;
    pkt_valid_i = 1'b0; pkt_sop_i = 1'b0; pkt_eop_i = 1'b0;
    pkt_empty_i = '0; pkt_flow_num_i = '0; pkt_err_i = 1'b0;
    #2;
    check_out("reset", 1'b0, 16'd0, 10'd0, 1'b0, 16'd0);
    do_reset();
    check_out("post_reset", 1'b0, 16'd0, 10'd0, 1'b0, 16'd0);

    // 1: single-beat packet, 8-3 = 5 bytes
    beat(1'b1, 1'b1, 3'd3, 10'd5, 1'b0);
    check_out("t1_strobe", 1'b1, 16'd5, 10'd5, 1'b0, 16'd0);
    idle();
    check_out("t1_after", 1'b0, 16'd5, 10'd5, 1'b0, 16'd0);

    // 2: three full beats -> 24
    beat(1'b1, 1'b0, 3'd0, 10'd9, 1'b0);
    check("t2_b1.en", 32'(pkt_size_en_o), 32'd0);
    beat(1'b0, 1'b0, 3'd0, 10'd0, 1'b0);
    beat(1'b0, 1'b1, 3'd0, 10'd0, 1'b0);
    check_out("t2_strobe", 1'b1, 16'd24, 10'd9, 1'b0, 16'd0);
    idle();
    check("t2_after.en", 32'(pkt_size_en_o), 32'd0);

    // 3: same with two idle cycles between beats
    beat(1'b1, 1'b0, 3'd0, 10'd9, 1'b0);
    idle(); idle();
    beat(1'b0, 1'b0, 3'd0, 10'd0, 1'b0);
    idle();
    check("t3_gap.en", 32'(pkt_size_en_o), 32'd0);
    idle();
    beat(1'b0, 1'b1, 3'd0, 10'd0, 1'b0);
    check_out("t3_strobe", 1'b1, 16'd24, 10'd9, 1'b0, 16'd0);
    idle();

    // 4: missing EOP, new single-beat packet aborts the old one
    do_reset();
    beat(1'b1, 1'b0, 3'd0, 10'd2, 1'b0);
    beat(1'b0, 1'b0, 3'd0, 10'd0, 1'b0);
    beat(1'b1, 1'b1, 3'd0, 10'd7, 1'b0);
    check_out("t4_abort", 1'b1, 16'd8, 10'd7, 1'b1, 16'd1);
    idle();
    check_out("t4_after", 1'b0, 16'd8, 10'd7, 1'b0, 16'd1);

    // 5: errored packet dropped, then stray non-SOP beat in IDLE
    do_reset();
    beat(1'b1, 1'b0, 3'd0, 10'd4, 1'b0);
    beat(1'b0, 1'b0, 3'd0, 10'd0, 1'b0);
    beat(1'b0, 1'b1, 3'd2, 10'd0, 1'b1);
    check_out("t5_errpkt", 1'b0, 16'd0, 10'd0, 1'b0, 16'd1);
    beat(1'b0, 1'b0, 3'd0, 10'd0, 1'b0);
    check_out("t5_stray", 1'b0, 16'd0, 10'd0, 1'b1, 16'd1);
    idle();
    check("t5_after.perr", 32'(proto_err_o), 32'd0);

    // back-to-back single-beat packets: strobe every cycle, no bubble
    beat(1'b1, 1'b1, 3'd0, 10'd1, 1'b0);
    check_out("b2b_1", 1'b1, 16'd8, 10'd1, 1'b0, 16'd1);
    beat(1'b1, 1'b1, 3'd1, 10'd2, 1'b0);
    check_out("b2b_2", 1'b1, 16'd7, 10'd2, 1'b0, 16'd1);
    beat(1'b1, 1'b1, 3'd7, 10'd1023, 1'b0);
    check_out("b2b_3", 1'b1, 16'd1, 10'd1023, 1'b0, 16'd1);
    idle();
    check("b2b_after.en", 32'(pkt_size_en_o), 32'd0);

    // abort plus errored single-beat packet in the same beat: +2 drops
    beat(1'b1, 1'b0, 3'd0, 10'd4, 1'b0);
    beat(1'b1, 1'b1, 3'd0, 10'd6, 1'b1);
    check_out("abort_err", 1'b0, 16'd1, 10'd1023, 1'b1, 16'd3);
    idle();

    // 6: 8200 beats * 8 bytes = 65600 -> saturates at 16'hFFFF
    do_reset();
    beat(1'b1, 1'b0, 3'd0, 10'd3, 1'b0);
    for (int i = 0; i < 8198; i++) beat(1'b0, 1'b0, 3'd0, 10'd0, 1'b0);
    beat(1'b0, 1'b1, 3'd0, 10'd0, 1'b0);
    check_out("t6_sat", 1'b1, 16'hFFFF, 10'd3, 1'b0, 16'd0);
    idle();

    // reset mid-packet discards it
    beat(1'b1, 1'b0, 3'd0, 10'd11, 1'b0);
    beat(1'b0, 1'b0, 3'd0, 10'd0, 1'b0);
    rst_n_i = 1'b0;
    #1;
    check_out("t6_rst", 1'b0, 16'd0, 10'd0, 1'b0, 16'd0);
    beat(1'b0, 1'b1, 3'd0, 10'd0, 1'b0);
    check_out("t6_rst_eop", 1'b0, 16'd0, 10'd0, 1'b0, 16'd0);
    rst_n_i = 1'b1;
    idle();
    beat(1'b0, 1'b1, 3'd0, 10'd0, 1'b0);
    check_out("t6_post_rst_stray", 1'b0, 16'd0, 10'd0, 1'b1, 16'd0);
    beat(1'b1, 1'b0, 3'd0, 10'd6, 1'b0);
    beat(1'b0, 1'b1, 3'd1, 10'd0, 1'b0);
    check_out("t6_15", 1'b1, 16'd15, 10'd6, 1'b0, 16'd0);
    idle();
    check("t6_after.en", 32'(pkt_size_en_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
